// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
package if_stage_pkg;

  // REQ: a fetch is outstanding. HOLD: a fetched instruction is parked
  // while the pipeline is frozen. KILL: the outstanding fetch is stale
  // and its response will be dropped.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_KILL = 2'd2
  } fetch_state_e;

  localparam int unsigned NOP    = 0;
  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/if_stage_pc_reg.sv
// Loadable address register with enable and asynchronous active-low reset.
module pc_reg #(
  parameter int unsigned       len      = 32,
  parameter logic [len-1:0]    RESET_PC = '0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           en,
  input  logic [len-1:0] d,
  output logic [len-1:0] q
);

  // Load on enable, return to RESET_PC on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)  q <= RESET_PC;
    else if (en) q <= d;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, instruction-memory handshake, IF/ID outputs,
// freeze buffering and branch redirect with a killed in-flight fetch.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned    len      = 32,
  parameter logic [len-1:0] RESET_PC = '0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           freeze,
  input  logic           branch_taken,
  input  logic [len-1:0] branch_target,
  output logic           imem_req,
  output logic [len-1:0] imem_addr,
  input  logic           imem_valid,
  input  logic [len-1:0] imem_data,
  output logic [len-1:0] pc_out,
  output logic [len-1:0] instruction_out,
  output logic           valid_out,
  output logic           flush_out
);

  localparam logic [len-1:0] INC     = len'(PC_INC);
  localparam logic [len-1:0] NOP_INS = len'(NOP);

  fetch_state_e   state_q, state_d;
  logic [len-1:0] buf_q, buf_d;
  logic [len-1:0] pc_out_q, pc_out_d;
  logic [len-1:0] instr_q, instr_d;
  logic           valid_q, valid_d;

  logic [len-1:0] pc_q, pc_d, req_addr_q, req_addr_d;
  logic           pc_en, req_addr_en;
  logic [len-1:0] next_addr, target;
  logic           unused_target_lsbs;

  assign next_addr          = req_addr_q + INC;
  assign target             = {branch_target[len-1:2], 2'b00};
  assign unused_target_lsbs = ^branch_target[1:0];

  pc_reg #(.len(len), .RESET_PC(RESET_PC)) u_pc (
    .clock (clock),
    .reset (reset),
    .en    (pc_en),
    .d     (pc_d),
    .q     (pc_q)
  );

  pc_reg #(.len(len), .RESET_PC(RESET_PC)) u_req_addr (
    .clock (clock),
    .reset (reset),
    .en    (req_addr_en),
    .d     (req_addr_d),
    .q     (req_addr_q)
  );

  assign imem_req        = reset && (state_q != S_HOLD);
  assign imem_addr       = req_addr_q;
  assign pc_out          = pc_out_q;
  assign instruction_out = instr_q;
  assign valid_out       = valid_q;
  assign flush_out       = branch_taken;

  // Next-state, address and output selection; branch overrides everything.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    pc_out_d    = pc_out_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    pc_en       = 1'b0;
    pc_d        = pc_q;
    req_addr_en = 1'b0;
    req_addr_d  = req_addr_q;

    if (branch_taken) begin
      pc_en   = 1'b1;
      pc_d    = target;
      instr_d = NOP_INS;
      valid_d = 1'b0;
      unique case (state_q)
        S_REQ: begin
          if (imem_valid) begin
            req_addr_en = 1'b1;
            req_addr_d  = target;
          end else begin
            // Keep req_addr so the open request stays stable until it completes.
            state_d = S_KILL;
          end
        end
        S_HOLD: begin
          req_addr_en = 1'b1;
          req_addr_d  = target;
          state_d     = S_REQ;
        end
        default: state_d = S_KILL;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem_valid) begin
            if (freeze) begin
              buf_d   = imem_data;
              state_d = S_HOLD;
            end else begin
              pc_out_d    = next_addr;
              instr_d     = imem_data;
              valid_d     = 1'b1;
              pc_en       = 1'b1;
              pc_d        = next_addr;
              req_addr_en = 1'b1;
              req_addr_d  = next_addr;
            end
          end else if (!freeze) begin
            instr_d = NOP_INS;
            valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!freeze) begin
            pc_out_d    = next_addr;
            instr_d     = buf_q;
            valid_d     = 1'b1;
            pc_en       = 1'b1;
            pc_d        = next_addr;
            req_addr_en = 1'b1;
            req_addr_d  = next_addr;
            state_d     = S_REQ;
          end
        end
        default: begin
          instr_d = NOP_INS;
          valid_d = 1'b0;
          if (imem_valid) begin
            req_addr_en = 1'b1;
            req_addr_d  = pc_q;
            state_d     = S_REQ;
          end
        end
      endcase
    end
  end

  // FSM, freeze buffer and IF/ID output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_REQ;
      buf_q    <= '0;
      pc_out_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage with a variable-latency memory model.
module tb_if_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;
  logic        flush_out;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  if_stage #(.len(32), .RESET_PC(32'h0)) dut (
    .clock           (clock),
    .reset           (reset),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_valid      (imem_valid),
    .imem_data       (imem_data),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out),
    .flush_out       (flush_out)
  );

  always #5 clock = ~clock;

  // Memory: answers a request after `lat` cycles; content is address + 0x100.
  int unsigned lat = 0;
  int unsigned wcnt;
  assign imem_valid = imem_req && (wcnt >= lat);
  assign imem_data  = imem_valid ? imem_addr + 32'h100 : 32'hDEAD_BEEF;

  always @(posedge clock or negedge reset) begin
    if (!reset)          wcnt <= 0;
    else if (imem_valid) wcnt <= 0;
    else if (imem_req)   wcnt <= wcnt + 1;
  end

  // Reference model: stream of fetch addresses and delivered instructions.
  logic [31:0] m_fetch, m_pc, m_out_pc, m_out_instr;
  logic        m_out_valid, m_dropping;
  logic [31:0] held_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fetch = 32'h0; m_pc = 32'h0; m_out_pc = 32'h0; m_out_instr = 32'h0;
    m_out_valid = 1'b0; m_dropping = 1'b0; held_q.delete();
  endtask

  task automatic emit(input logic [31:0] d);
    m_out_pc    = m_fetch + 32'd4;
    m_out_instr = d;
    m_out_valid = 1'b1;
    m_fetch     = m_fetch + 32'd4;
    m_pc        = m_fetch;
  endtask

  task automatic model_step(input logic frz, input logic br, input logic [31:0] tgt,
                            input logic v, input logic [31:0] d);
    logic [31:0] t;
    t = {tgt[31:2], 2'b00};
    if (br) begin
      m_out_instr = 32'h0; m_out_valid = 1'b0; m_pc = t;
      if (m_dropping) begin
        m_dropping = 1'b1;
      end else if (held_q.size() != 0) begin
        held_q.delete(); m_fetch = t;
      end else if (v) begin
        m_fetch = t;
      end else begin
        m_dropping = 1'b1;
      end
    end else if (m_dropping) begin
      m_out_instr = 32'h0; m_out_valid = 1'b0;
      if (v) begin m_dropping = 1'b0; m_fetch = m_pc; end
    end else if (held_q.size() != 0) begin
      if (!frz) emit(held_q.pop_front());
    end else if (v) begin
      if (frz) held_q.push_back(d);
      else     emit(d);
    end else if (!frz) begin
      m_out_instr = 32'h0; m_out_valid = 1'b0;
    end
  endtask

  // One clock cycle: drive, check combinational outputs, advance, check registers.
  task automatic cycle(input logic frz, input logic br, input logic [31:0] tgt);
    freeze = frz; branch_taken = br; branch_target = tgt;
    #1;
    chk("imem_req",  {31'h0, imem_req},  {31'h0, (held_q.size() == 0)});
    chk("imem_addr", imem_addr, m_fetch);
    chk("flush_out", {31'h0, flush_out}, {31'h0, br});
    model_step(frz, br, tgt, imem_valid, imem_data);
    @(posedge clock); #1;
    chk("pc_out",    pc_out, m_out_pc);
    chk("instr_out", instruction_out, m_out_instr);
    chk("valid_out", {31'h0, valid_out}, {31'h0, m_out_valid});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc_out"}, pc_out, 32'h0);
    chk({tag, "_instr"},  instruction_out, 32'h0);
    chk({tag, "_valid"},  {31'h0, valid_out}, 32'h0);
    chk({tag, "_req"},    {31'h0, imem_req},  32'h0);
    chk({tag, "_addr"},   imem_addr, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    model_reset();
    #2;
    chk_reset_vals("rst");
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;

    // 1) zero-latency stream
    lat = 0;
    cycle(1'b0, 1'b0, 32'h0);
    chk("t1_pc0",  pc_out, 32'h4);
    chk("t1_ins0", instruction_out, 32'h100);
    cycle(1'b0, 1'b0, 32'h0);
    chk("t1_pc1",  pc_out, 32'h8);
    chk("t1_ins1", instruction_out, 32'h104);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0);

    // 2) one-cycle latency, alternating bubbles
    lat = 1;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0);

    // 3) freeze while a response arrives
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);

    // 4) branch to 0x43 with a 3-cycle fetch outstanding
    lat = 0;
    cycle(1'b0, 1'b0, 32'h0);
    lat = 3;
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h43);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (valid_out) begin found = 1'b1; chk("t4_first_pc", pc_out, 32'h44); end
    end
    chk("t4_found", {31'h0, found}, 32'h1);

    // 5) branch during freeze while an instruction is held
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (held_q.size() != 0) found = 1'b1;
    end
    chk("t5_held", {31'h0, found}, 32'h1);
    cycle(1'b1, 1'b1, 32'h202);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (valid_out) begin found = 1'b1; chk("t5_first_pc", pc_out, 32'h204); end
    end
    chk("t5_found", {31'h0, found}, 32'h1);

    // 6a) reset in the middle of a kill
    lat = 3;
    cycle(1'b0, 1'b1, 32'h800);
    cycle(1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    #1;
    chk_reset_vals("midkill");
    model_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    lat = 0;
    cycle(1'b0, 1'b0, 32'h0);
    chk("t6_pc_after_rst", pc_out, 32'h4);

    // 6b) address wrap
    cycle(1'b0, 1'b1, 32'hFFFF_FFFE);
    cycle(1'b0, 1'b0, 32'h0);
    chk("t6_wrap_pc",  pc_out, 32'h0);
    chk("t6_wrap_ins", instruction_out, 32'h0000_00FC);

    // Randomized traffic
    for (int seg = 0; seg < 40; seg++) begin
      lat = $urandom_range(0, 3);
      for (int i = 0; i < 15; i++)
        cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
